// File: rtl/io_out_port_if.sv
// Bus-side write strobe, external valid/ready handshake and status flags of io_out_port.
// The slave modport is the port block; the master modport is whoever drives the bus and consumes words.
interface io_out_port_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
);
  logic             bus_O1_input_en;
  logic [WIDTH-1:0] bus_O1_input;
  logic [WIDTH-1:0] external_O1_output;
  logic             external_O1_valid;
  logic             external_O1_ready;
  logic             O1_full;
  logic             O1_empty;
  logic [CW-1:0]    O1_count;
  logic             O1_overflow;
  logic             O1_overflow_clr;

  modport slave (
    input  bus_O1_input_en, bus_O1_input, external_O1_ready, O1_overflow_clr,
    output external_O1_output, external_O1_valid, O1_full, O1_empty, O1_count, O1_overflow
  );

  modport master (
    output bus_O1_input_en, bus_O1_input, external_O1_ready, O1_overflow_clr,
    input  external_O1_output, external_O1_valid, O1_full, O1_empty, O1_count, O1_overflow
  );
endinterface

// File: rtl/io_out_port.sv
// Bus-to-external output port: FIFO of bus writes presented first-word-fall-through
// over valid/ready, with a registered head word and sticky overflow on dropped writes.
module io_out_port #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic            O1_clock,
  input  logic            O1_reset,
  io_out_port_if.slave    io
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q;
  logic             ovf_q, ovf_d;
  logic             full, push, pop;

  assign full   = (count_q == CW'(DEPTH));
  assign pop    = valid_q && io.external_O1_ready;
  assign push   = io.bus_O1_input_en && (!full || pop);
  assign rd_nxt = rd_ptr_q + AW'(1);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Head register is loaded ahead of time with whatever becomes head after this edge,
  // so the output never depends combinationally on ready.
  always_comb begin
    out_d = out_q;
    if (count_q == '0) begin
      if (push) out_d = io.bus_O1_input;
    end else if (pop) begin
      if (count_q == CW'(1)) begin
        if (push) out_d = io.bus_O1_input;
      end else begin
        out_d = mem_q[rd_nxt];
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (io.bus_O1_input_en && !push) ovf_d = 1'b1;
    else if (io.O1_overflow_clr)     ovf_d = 1'b0;
  end

  always_ff @(posedge O1_clock) begin
    if (!O1_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= io.bus_O1_input;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_nxt;
      count_q <= count_d;
      out_q   <= out_d;
      valid_q <= (count_d != '0);
      ovf_q   <= ovf_d;
    end
  end

  assign io.external_O1_output = out_q;
  assign io.external_O1_valid  = valid_q;
  assign io.O1_full            = full;
  assign io.O1_empty           = (count_q == '0);
  assign io.O1_count           = count_q;
  assign io.O1_overflow        = ovf_q;
endmodule

// File: tb/tb_io_out_port.sv
// Directed bench for io_out_port: queue-based reference model checked every cycle,
// plus literal expectations on flags and on the sequence of words consumed.
module tb_io_out_port;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  io_out_port_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) io ();
  io_out_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .O1_clock (clk),
    .O1_reset (rstn),
    .io       (io.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_out;
  logic             m_ovf;
  logic             started = 1'b0;
  logic [WIDTH-1:0] dut_log[$];

  // Reference model: a plain queue, updated from the inputs seen at each edge.
  always @(posedge clk) begin
    if (!rstn) begin
      mq.delete();
      m_out   = '0;
      m_ovf   = 1'b0;
      started = 1'b1;
    end else if (started) begin
      logic mpop, mpush;
      if (io.external_O1_valid && io.external_O1_ready)
        dut_log.push_back(io.external_O1_output);
      mpop  = (mq.size() > 0) && io.external_O1_ready;
      mpush = io.bus_O1_input_en && ((mq.size() < DEPTH) || mpop);
      if (mpop)  void'(mq.pop_front());
      if (mpush) mq.push_back(io.bus_O1_input);
      if (io.bus_O1_input_en && !mpush) m_ovf = 1'b1;
      else if (io.O1_overflow_clr)      m_ovf = 1'b0;
      if (mq.size() > 0) m_out = mq[0];
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic             e_valid, e_full, e_empty;
      logic [WIDTH-1:0] e_cnt;
      e_valid = (mq.size() > 0);
      e_full  = (mq.size() == DEPTH);
      e_empty = (mq.size() == 0);
      e_cnt   = WIDTH'(mq.size());
      vectors++;
      if (io.external_O1_valid !== e_valid || io.external_O1_output !== m_out ||
          WIDTH'(io.O1_count) !== e_cnt || io.O1_full !== e_full ||
          io.O1_empty !== e_empty || io.O1_overflow !== m_ovf) begin
        miscompares++;
        $display("FAIL cycle_model t=%0t: got v=%b out=%h cnt=%0d f=%b e=%b ovf=%b, want v=%b out=%h cnt=%0d f=%b e=%b ovf=%b",
                 $time, io.external_O1_valid, io.external_O1_output, io.O1_count, io.O1_full,
                 io.O1_empty, io.O1_overflow, e_valid, m_out, e_cnt, e_full, e_empty, m_ovf);
      end
    end
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input logic [WIDTH-1:0] exp[$]);
    logic bad;
    bad = (dut_log.size() != exp.size());
    for (int i = 0; i < exp.size() && !bad; i++)
      if (dut_log[i] !== exp[i]) bad = 1'b1;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL %s: got %p, want %p", name, dut_log, exp);
    end
  endtask

  task automatic step(input logic en, input logic [WIDTH-1:0] d, input logic rdy,
                      input logic clr, input logic rn);
    io.bus_O1_input_en   = en;
    io.bus_O1_input      = d;
    io.external_O1_ready = rdy;
    io.O1_overflow_clr   = clr;
    rstn                 = rn;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    io.bus_O1_input_en   = 1'b0;
    io.bus_O1_input      = '0;
    io.external_O1_ready = 1'b0;
    io.O1_overflow_clr   = 1'b0;
    rstn                 = 1'b0;
    @(negedge clk);

    // T1: reset held two cycles with strobe active
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", WIDTH'(io.external_O1_valid), 16'd0);
    chk("t1_empty", WIDTH'(io.O1_empty), 16'd1);
    chk("t1_count", WIDTH'(io.O1_count), 16'd0);
    chk("t1_out", io.external_O1_output, 16'h0000);
    chk("t1_ovf", WIDTH'(io.O1_overflow), 16'd0);

    // T2: single word, then consume it
    step(1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b1);
    chk("t2_valid", WIDTH'(io.external_O1_valid), 16'd1);
    chk("t2_out", io.external_O1_output, 16'hA5A5);
    chk("t2_count", WIDTH'(io.O1_count), 16'd1);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    chk("t2_valid_after_pop", WIDTH'(io.external_O1_valid), 16'd0);
    chk("t2_empty_after_pop", WIDTH'(io.O1_empty), 16'd1);
    chk("t2_out_held", io.external_O1_output, 16'hA5A5);

    // T3: fill and overflow, then drain
    dut_log.delete();
    for (int i = 1; i <= 5; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b1);
    chk("t3_full", WIDTH'(io.O1_full), 16'd1);
    chk("t3_count", WIDTH'(io.O1_count), 16'd4);
    chk("t3_ovf", WIDTH'(io.O1_overflow), 16'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    chk_log("t3_drain_order", '{16'd1, 16'd2, 16'd3, 16'd4});
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    chk("t3_ovf_cleared", WIDTH'(io.O1_overflow), 16'd0);

    // T4: push+pop at full, then overflow set and clear together
    for (int i = 10; i <= 13; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b1);
    dut_log.delete();
    step(1'b1, 16'h00FF, 1'b1, 1'b0, 1'b1);
    chk("t4_count", WIDTH'(io.O1_count), 16'd4);
    chk("t4_ovf", WIDTH'(io.O1_overflow), 16'd0);
    step(1'b1, 16'h0BAD, 1'b0, 1'b1, 1'b1);
    chk("t4_set_wins", WIDTH'(io.O1_overflow), 16'd1);
    step(1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    chk_log("t4_order", '{16'd10, 16'd11, 16'd12, 16'd13, 16'h00FF});
    chk("t4_ovf_cleared", WIDTH'(io.O1_overflow), 16'd0);

    // T5: streaming with ready held high
    dut_log.delete();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, WIDTH'(i), 1'b1, 1'b0, 1'b1);
      chk("t5_count_le1", WIDTH'(io.O1_count <= 1), 16'd1);
    end
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    begin
      logic [WIDTH-1:0] exp5[$];
      for (int i = 0; i < 20; i++) exp5.push_back(WIDTH'(i));
      chk_log("t5_stream", exp5);
    end

    // T6: reset mid-operation during a push
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(16'h50 + i), 1'b0, 1'b0, 1'b1);
    chk("t6_count3", WIDTH'(io.O1_count), 16'd3);
    step(1'b1, 16'h0099, 1'b0, 1'b0, 1'b0);
    chk("t6_empty", WIDTH'(io.O1_empty), 16'd1);
    chk("t6_out_zero", io.external_O1_output, 16'h0000);
    dut_log.delete();
    step(1'b1, 16'd7, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'd8, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    chk_log("t6_after_reset", '{16'd7, 16'd8});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
